// File: rtl/aux_retry_ctrl.sv
// AUX request launcher with timeout/defer retry; tx_start one cycle after accept, retry relaunch RETRY_GAP+1 cycles after failure.
// Backpressure: req_ready only in IDLE, so upstream holds req_vld until the previous request has completed.
module aux_retry_ctrl #(
  parameter int MAX_TO_RETRY = 3,
  parameter int MAX_DEFER    = 7,
  parameter int RETRY_GAP    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_vld,
  output logic       req_ready,
  output logic       tx_start,
  input  logic       timer_timeout,
  input  logic       rx_reply_vld,
  input  logic [1:0] rx_reply_cmd,
  output logic       done_vld,
  output logic [1:0] done_status,
  output logic [3:0] attempt_cnt,
  output logic       busy
);

  localparam logic [2:0] MaxToC   = 3'(MAX_TO_RETRY);
  localparam logic [2:0] MaxDfC   = 3'(MAX_DEFER);
  localparam logic [7:0] GapLoadC = 8'(RETRY_GAP - 1);

  localparam logic [1:0] StAck   = 2'b00;
  localparam logic [1:0] StNack  = 2'b01;
  localparam logic [1:0] StDfExh = 2'b10;
  localparam logic [1:0] StToExh = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] to_cnt_q, to_cnt_d;
  logic [2:0] df_cnt_q, df_cnt_d;
  logic [3:0] attempt_q, attempt_d;
  logic [7:0] gap_q, gap_d;
  logic [1:0] status_q, status_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      to_cnt_q  <= '0;
      df_cnt_q  <= '0;
      attempt_q <= '0;
      gap_q     <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      df_cnt_q  <= df_cnt_d;
      attempt_q <= attempt_d;
      gap_q     <= gap_d;
      status_q  <= status_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    df_cnt_d  = df_cnt_q;
    attempt_d = attempt_q;
    gap_d     = gap_q;
    status_d  = status_q;
    case (state_q)
      S_IDLE: begin
        if (req_vld) begin
          to_cnt_d  = '0;
          df_cnt_d  = '0;
          attempt_d = '0;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        attempt_d = attempt_q + 4'd1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // A reply in the same cycle as a timeout takes priority; the timeout is dropped.
        if (rx_reply_vld) begin
          case (rx_reply_cmd)
            2'b00: begin
              status_d = StAck;
              state_d  = S_DONE;
            end
            2'b10: begin
              if (df_cnt_q < MaxDfC) begin
                df_cnt_d = df_cnt_q + 3'd1;
                gap_d    = GapLoadC;
                state_d  = S_GAP;
              end else begin
                status_d = StDfExh;
                state_d  = S_DONE;
              end
            end
            default: begin
              status_d = StNack;
              state_d  = S_DONE;
            end
          endcase
        end else if (timer_timeout) begin
          if (to_cnt_q < MaxToC) begin
            to_cnt_d = to_cnt_q + 3'd1;
            gap_d    = GapLoadC;
            state_d  = S_GAP;
          end else begin
            status_d = StToExh;
            state_d  = S_DONE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 8'd0) begin
          state_d = S_LAUNCH;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign tx_start    = (state_q == S_LAUNCH);
  assign done_vld    = (state_q == S_DONE);
  assign done_status = status_q;
  assign attempt_cnt = attempt_q;

endmodule

// File: tb/tb_aux_retry_ctrl.sv
// Directed bench for aux_retry_ctrl at default parameters (MAX_TO_RETRY=3, MAX_DEFER=7, RETRY_GAP=8).
module tb_aux_retry_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_vld = 1'b0;
  logic       req_ready;
  logic       tx_start;
  logic       timer_timeout = 1'b0;
  logic       rx_reply_vld = 1'b0;
  logic [1:0] rx_reply_cmd = 2'b00;
  logic       done_vld;
  logic [1:0] done_status;
  logic [3:0] attempt_cnt;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_cnt   = 0;
  int done_cnt = 0;
  int tx0, done0;

  aux_retry_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_vld       (req_vld),
    .req_ready     (req_ready),
    .tx_start      (tx_start),
    .timer_timeout (timer_timeout),
    .rx_reply_vld  (rx_reply_vld),
    .rx_reply_cmd  (rx_reply_cmd),
    .done_vld      (done_vld),
    .done_status   (done_status),
    .attempt_cnt   (attempt_cnt),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_start === 1'b1) tx_cnt <= tx_cnt + 1;
    if (done_vld === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept a request at the first IDLE cycle; returns at the negedge of the tx_start cycle.
  task automatic do_request();
    @(negedge clk);
    chk("req_ready_before_accept", req_ready, 1);
    req_vld = 1'b1;
    @(negedge clk);
    req_vld = 1'b0;
    chk("tx_start_after_accept", tx_start, 1);
  endtask

  // One failed attempt (timeout or DEFER) followed by the gap and relaunch.
  task automatic fail_retry(input bit is_to, input string tag);
    logic saw;
    @(negedge clk);
    if (is_to) timer_timeout = 1'b1;
    else begin
      rx_reply_vld = 1'b1;
      rx_reply_cmd = 2'b10;
    end
    @(negedge clk);
    timer_timeout = 1'b0;
    rx_reply_vld  = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      saw = saw | tx_start | done_vld;
    end
    chk({tag, "_gap_quiet"}, saw, 0);
    @(negedge clk);
    chk({tag, "_relaunch"}, tx_start, 1);
  endtask

  // Final event in WAIT_REPLY; returns at the negedge of the DONE cycle.
  task automatic final_reply(input bit is_to, input logic [1:0] cmd, input logic [1:0] exp_st,
                             input logic [3:0] exp_att, input string tag);
    @(negedge clk);
    if (is_to) timer_timeout = 1'b1;
    else begin
      rx_reply_vld = 1'b1;
      rx_reply_cmd = cmd;
    end
    @(negedge clk);
    timer_timeout = 1'b0;
    rx_reply_vld  = 1'b0;
    chk({tag, "_done_vld"}, done_vld, 1);
    chk({tag, "_status"}, done_status, exp_st);
    chk({tag, "_attempts"}, attempt_cnt, exp_att);
  endtask

  initial begin
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_done_vld", done_vld, 0);
    chk("rst_status", done_status, 0);
    chk("rst_attempt", attempt_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ACK, reply several cycles after launch; WAIT holds with no input.
    tx0 = tx_cnt;
    do_request();
    repeat (3) @(negedge clk);
    chk("ack_wait_busy", busy, 1);
    chk("ack_wait_no_done", done_vld, 0);
    final_reply(1'b0, 2'b00, 2'b00, 4'd1, "ack");
    chk("ack_tx_pulses", tx_cnt - tx0, 1);
    @(negedge clk);
    chk("ack_busy_after", busy, 0);
    chk("ack_done_one_cycle", done_vld, 0);
    chk("ack_status_hold", done_status, 0);
    chk("ack_attempt_hold", attempt_cnt, 1);

    // Timeout exhaustion: 3 retries then status 11.
    tx0 = tx_cnt;
    do_request();
    for (int i = 0; i < 3; i++) fail_retry(1'b1, "to");
    final_reply(1'b1, 2'b00, 2'b11, 4'd4, "to_exh");
    chk("to_tx_pulses", tx_cnt - tx0, 4);

    // Defer, defer, ACK (request accepted at first IDLE cycle after DONE).
    do_request();
    chk("b2b_attempt_cleared", attempt_cnt, 0);
    fail_retry(1'b0, "df");
    fail_retry(1'b0, "df");
    final_reply(1'b0, 2'b00, 2'b00, 4'd3, "df_ack");

    // Defer exhaustion: 7 retries then status 10.
    do_request();
    for (int i = 0; i < 7; i++) fail_retry(1'b0, "dfx");
    final_reply(1'b0, 2'b10, 2'b10, 4'd8, "df_exh");

    // Mixed: 2 timeouts, 7 defers, ACK.
    tx0 = tx_cnt;
    do_request();
    fail_retry(1'b1, "mix_to");
    fail_retry(1'b1, "mix_to");
    for (int i = 0; i < 7; i++) fail_retry(1'b0, "mix_df");
    final_reply(1'b0, 2'b00, 2'b00, 4'd10, "mix");
    chk("mix_tx_pulses", tx_cnt - tx0, 10);

    // Reserved reply code behaves as NACK.
    do_request();
    final_reply(1'b0, 2'b11, 2'b01, 4'd1, "rsvd");

    // NACK collides with timeout: reply wins, no retry.
    do_request();
    @(negedge clk);
    rx_reply_vld  = 1'b1;
    rx_reply_cmd  = 2'b01;
    timer_timeout = 1'b1;
    @(negedge clk);
    rx_reply_vld  = 1'b0;
    timer_timeout = 1'b0;
    chk("coll_done_vld", done_vld, 1);
    chk("coll_status", done_status, 2'b01);
    chk("coll_attempts", attempt_cnt, 1);
    @(negedge clk);
    chk("coll_no_retry", tx_start, 0);
    chk("coll_idle", req_ready, 1);

    // Reset asserted during GAP.
    do_request();
    @(negedge clk);
    timer_timeout = 1'b1;
    @(negedge clk);
    timer_timeout = 1'b0;
    repeat (3) @(negedge clk);
    chk("gap_busy", busy, 1);
    done0 = done_cnt;
    tx0   = tx_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_req_ready", req_ready, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_tx_start", tx_start, 0);
    chk("rstmid_done_vld", done_vld, 0);
    chk("rstmid_status", done_status, 0);
    chk("rstmid_attempt", attempt_cnt, 0);
    repeat (12) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstmid_no_done", done_cnt - done0, 0);
    chk("rstmid_no_tx", tx_cnt - tx0, 0);
    do_request();
    final_reply(1'b0, 2'b00, 2'b00, 4'd1, "post_rst");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aux_retry_ctrl.md
# aux_retry_ctrl

AUX transaction retry controller sitting directly downstream of the AUX timeout timer and the bidirectional-interface reply decoder. It launches each AUX request toward the transmit mux, then waits for either a decoded sink reply or `timer_timeout`. It retries on timeout or AUX_DEFER within configured limits, and returns one final completion status to the link-policy layer.

## Interface
Parameters:
- `MAX_TO_RETRY`, default 3: retries allowed after timeouts, excluding the first attempt; range 0-7.
- `MAX_DEFER`, default 7: retries allowed after AUX_DEFER replies; range 0-7.
- `RETRY_GAP`, default 8: idle cycles between a failed attempt and the relaunch; range 1-255.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_vld` in 1: upstream request valid.
- `req_ready` out 1: high only in IDLE; a request is accepted when `req_vld && req_ready`.
- `tx_start` out 1: one-cycle pulse; launches the transmitter/mux for one attempt.
- `timer_timeout` in 1: one-cycle pulse from the timeout timer.
- `rx_reply_vld` in 1: one-cycle pulse; a decoded reply is present.
- `rx_reply_cmd` in 2: reply code, valid with `rx_reply_vld`.
  - 00 = ACK, 01 = NACK, 10 = DEFER.
  - 11 = reserved, treated as NACK.
- `done_vld` out 1: one-cycle completion pulse.
- `done_status` out 2: final status, valid with `done_vld`.
  - 00 = ACK, 01 = NACK.
  - 10 = defer limit exhausted, 11 = timeout limit exhausted.
- `attempt_cnt` out 4: number of attempts launched for the current request; holds after done until the next acceptance.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, LAUNCH, WAIT_REPLY, GAP, DONE. All outputs are registered or decoded from state only.
- Two internal counters track the request:
  - `to_cnt`, 3 bits: timeout retries used.
  - `df_cnt`, 3 bits: defer retries used.
  - Both clear on acceptance.
- IDLE:
  - `req_ready` = 1.
  - On acceptance: clear `to_cnt`, `df_cnt` and `attempt_cnt`; go to LAUNCH.
- LAUNCH:
  - Assert `tx_start` for exactly one cycle.
  - Increment `attempt_cnt` (4-bit; the maximum reachable is 1 + 7 + 7 = 15, so it never wraps).
  - Go to WAIT_REPLY.
- WAIT_REPLY, when `rx_reply_vld` = 1:
  - ACK: go to DONE with status 00.
  - NACK or reserved: go to DONE with status 01.
  - DEFER with `df_cnt < MAX_DEFER`: increment `df_cnt`, go to GAP.
  - DEFER with `df_cnt == MAX_DEFER`: go to DONE with status 10.
- WAIT_REPLY, when `timer_timeout` = 1 and no reply that cycle:
  - `to_cnt < MAX_TO_RETRY`: increment `to_cnt`, go to GAP.
  - `to_cnt == MAX_TO_RETRY`: go to DONE with status 11.
- WAIT_REPLY with neither input: remain indefinitely. The timeout timer guarantees progress.
- GAP:
  - The gap counter (8-bit) loads `RETRY_GAP-1` on entry and decrements each cycle.
  - At 0, go to LAUNCH.
  - `rx_reply_vld` and `timer_timeout` are ignored in GAP.
- DONE:
  - `done_vld` = 1 for one cycle, with `done_status` valid.
  - Go to IDLE.
  - `done_status` holds its value until the next DONE.
- Outside WAIT_REPLY, `rx_reply_vld` and `timer_timeout` have no effect.
- `req_vld` outside IDLE is not accepted; upstream must hold it.

## Timing
- Reset values: `req_ready`=1 (state IDLE); `tx_start`, `done_vld`, `busy` = 0; `done_status`=00; `attempt_cnt`=0; all counters 0.
- Acceptance at edge k: `tx_start`=1 during cycle k+1, and WAIT_REPLY starts at edge k+2.
- Reply or timeout sampled at edge m in WAIT_REPLY:
  - Final outcome: `done_vld`=1 during cycle m+1; `req_ready`=1 from edge m+2.
  - Retry: GAP spans cycles m+1 to m+RETRY_GAP, then `tx_start` in cycle m+RETRY_GAP+1.
- Back-to-back: a new request can be accepted at edge m+2, the first IDLE cycle after DONE.
- Simultaneous `rx_reply_vld` and `timer_timeout` in the same cycle: the reply wins and the timeout is discarded; `to_cnt` is unchanged.
- `rst_n` asserted mid-transaction: immediately return to IDLE with reset values. A `tx_start` in flight is dropped, and no `done_vld` is produced.

## Test plan
- Single ACK:
  - Stimulus: request; reply ACK 5 cycles after `tx_start`.
  - Response: one `tx_start`; `done_vld` with status 00; `attempt_cnt`=1; `busy` low the cycle after done.
- Timeout exhaustion, `MAX_TO_RETRY`=3, `RETRY_GAP`=8:
  - Stimulus: four `timer_timeout` pulses, no reply.
  - Response: 4 `tx_start` pulses, each 9 cycles after the previous timeout; status 11; `attempt_cnt`=4.
- Defer then ACK:
  - Stimulus: DEFER, DEFER, ACK.
  - Response: 3 attempts; status 00; `attempt_cnt`=3.
- Defer exhaustion, `MAX_DEFER`=7:
  - Stimulus: 8 DEFER replies.
  - Response: status 10; `attempt_cnt`=8.
  - A mixed sequence of 2 timeouts plus 7 defers then ACK completes with `attempt_cnt`=10 and status 00.
- Collision and reset:
  - Reply NACK and `timer_timeout` in the same cycle → status 01, no retry.
  - Separately, `rst_n` low during GAP → all outputs return to reset values; no `done_vld`; the next request starts with `attempt_cnt`=1.
